uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: baud/16x-baud tick dividers plus an 11-bit framed shifter.
// Optional feature macro: UART_TX_PARITY_EN (even parity in bit 9; otherwise a second stop bit).
module uart_transmitter #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  baud_sel,
  input  logic [7:0]  data_in,
  output logic        intx,
  output logic        inrx,
  output logic [10:0] out_tx,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned FRAME_W = 11;

  localparam int unsigned BAUD_0 = 9600;
  localparam int unsigned BAUD_1 = 115200;
  localparam int unsigned BAUD_2 = 460800;
  localparam int unsigned BAUD_3 = 921600;

  localparam logic [CNT_W-1:0] DIV_TX_0 = CNT_W'(CLK_FREQ / BAUD_0);
  localparam logic [CNT_W-1:0] DIV_TX_1 = CNT_W'(CLK_FREQ / BAUD_1);
  localparam logic [CNT_W-1:0] DIV_TX_2 = CNT_W'(CLK_FREQ / BAUD_2);
  localparam logic [CNT_W-1:0] DIV_TX_3 = CNT_W'(CLK_FREQ / BAUD_3);
  localparam logic [CNT_W-1:0] DIV_RX_0 = CNT_W'(CLK_FREQ / (16 * BAUD_0));
  localparam logic [CNT_W-1:0] DIV_RX_1 = CNT_W'(CLK_FREQ / (16 * BAUD_1));
  localparam logic [CNT_W-1:0] DIV_RX_2 = CNT_W'(CLK_FREQ / (16 * BAUD_2));
  localparam logic [CNT_W-1:0] DIV_RX_3 = CNT_W'(CLK_FREQ / (16 * BAUD_3));

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(10);
  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [1:0]         baud_q;
  logic               baud_chg;
  logic [CNT_W-1:0]   div_tx_m1;
  logic [CNT_W-1:0]   div_rx_m1;
  logic [CNT_W-1:0]   tx_cnt;
  logic [CNT_W-1:0]   tx_cnt_d;
  logic [CNT_W-1:0]   rx_cnt;
  logic [CNT_W-1:0]   rx_cnt_d;
  logic               intx_d;
  logic               inrx_d;

  logic [0:0]         state;
  logic [0:0]         state_d;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   idx_inc;
  logic [FRAME_W-1:0] frame_d;
  logic [FRAME_W-1:0] new_frame;
  logic [FRAME_W-1:0] frame_shift;
  logic               parity_bit;
  logic               tx_d;
  logic               busy_d;

  // Divider terminal counts for the currently registered baud selection
  always_comb begin
    div_tx_m1 = DIV_TX_2 - CNT_W'(1);
    div_rx_m1 = DIV_RX_2 - CNT_W'(1);
    case (baud_q)
      2'b00: begin
        div_tx_m1 = DIV_TX_0 - CNT_W'(1);
        div_rx_m1 = DIV_RX_0 - CNT_W'(1);
      end
      2'b01: begin
        div_tx_m1 = DIV_TX_1 - CNT_W'(1);
        div_rx_m1 = DIV_RX_1 - CNT_W'(1);
      end
      2'b10: begin
        div_tx_m1 = DIV_TX_2 - CNT_W'(1);
        div_rx_m1 = DIV_RX_2 - CNT_W'(1);
      end
      default: begin
        div_tx_m1 = DIV_TX_3 - CNT_W'(1);
        div_rx_m1 = DIV_RX_3 - CNT_W'(1);
      end
    endcase
  end

  // A baud change restarts both dividers from zero and suppresses that edge's tick
  always_comb begin
    baud_chg = (baud_sel != baud_q);
    tx_cnt_d = tx_cnt + CNT_W'(1);
    rx_cnt_d = rx_cnt + CNT_W'(1);
    if (baud_chg || (tx_cnt == div_tx_m1)) begin
      tx_cnt_d = '0;
    end
    if (baud_chg || (rx_cnt == div_rx_m1)) begin
      rx_cnt_d = '0;
    end
    intx_d = !baud_chg && (tx_cnt_d == div_tx_m1);
    inrx_d = !baud_chg && (rx_cnt_d == div_rx_m1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_q <= baud_sel;
      tx_cnt <= '0;
      rx_cnt <= '0;
      intx   <= 1'b0;
      inrx   <= 1'b0;
    end else begin
      baud_q <= baud_sel;
      tx_cnt <= tx_cnt_d;
      rx_cnt <= rx_cnt_d;
      intx   <= intx_d;
      inrx   <= inrx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  assign parity_bit = ^data_in;
`else
  assign parity_bit = 1'b1;
`endif

  assign new_frame   = {1'b1, parity_bit, data_in, 1'b0};
  assign idx_inc     = idx + IDX_W'(1);
  assign frame_shift = out_tx >> idx_inc;

  // Next-state and registered-output logic; frames run back-to-back once started
  always_comb begin
    state_d = state;
    idx_d   = idx;
    frame_d = out_tx;
    tx_d    = tx;
    busy_d  = busy;
    case (state)
      ST_IDLE: begin
        if (intx) begin
          state_d = ST_SEND;
          idx_d   = '0;
          frame_d = new_frame;
          tx_d    = new_frame[0];
          busy_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (intx) begin
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            frame_d = new_frame;
            tx_d    = new_frame[0];
          end else begin
            idx_d = idx_inc;
            tx_d  = frame_shift[0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        frame_d = IDLE_FRAME;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      idx    <= '0;
      out_tx <= IDLE_FRAME;
      tx     <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      out_tx <= frame_d;
      tx     <= tx_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: cycle-level reference model plus directed timing/frame checks.
module tb_uart_transmitter;

  localparam int unsigned CLK_HZ = 100_000_000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  baud_sel;
  logic [7:0]  data_in;
  logic        intx;
  logic        inrx;
  logic [10:0] out_tx;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_n = 0;
  int          m_k = 0;
  logic        m_intx = 1'b0;
  logic        m_inrx = 1'b0;
  logic        m_tx = 1'b1;
  logic        m_busy = 1'b0;
  logic [10:0] m_frame = 11'h7FF;
  logic [1:0]  m_baud = 2'b10;

  uart_transmitter #(.CLK_FREQ(CLK_HZ)) dut (
    .clk(clk),
    .reset(reset),
    .baud_sel(baud_sel),
    .data_in(data_in),
    .intx(intx),
    .inrx(inrx),
    .out_tx(out_tx),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int baud_of(input logic [1:0] s);
    case (s)
      2'b00:   return 9600;
      2'b01:   return 115200;
      2'b10:   return 460800;
      default: return 921600;
    endcase
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    logic par;
`ifdef UART_TX_PARITY_EN
    par = ^d;
`else
    par = 1'b1;
`endif
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare all outputs
  task automatic step();
    logic       tick_prev;
    logic [7:0] d;
    logic       rst;
    logic       chg;
    int         dtx;
    int         drx;
    int         bit_no;
    tick_prev = m_intx;
    d   = data_in;
    rst = reset;
    chg = (baud_sel != m_baud);
    @(posedge clk);
    #1;
    if (!rst) begin
      m_n = 0; m_k = 0; m_intx = 1'b0; m_inrx = 1'b0;
      m_baud = baud_sel; m_frame = 11'h7FF; m_tx = 1'b1; m_busy = 1'b0;
    end else begin
      if (tick_prev) begin
        bit_no = m_k % 11;
        if (bit_no == 0) m_frame = make_frame(d);
        m_tx = m_frame[bit_no];
        m_busy = 1'b1;
        m_k++;
      end
      if (chg) begin
        m_n = 0;
        m_baud = baud_sel;
      end else begin
        m_n++;
      end
      dtx = CLK_HZ / baud_of(m_baud);
      drx = CLK_HZ / (16 * baud_of(m_baud));
      m_intx = !chg && ((m_n % dtx) == dtx - 1);
      m_inrx = !chg && ((m_n % drx) == drx - 1);
    end
    check("intx",   32'(intx),   32'(m_intx));
    check("inrx",   32'(inrx),   32'(m_inrx));
    check("tx",     32'(tx),     32'(m_tx));
    check("busy",   32'(busy),   32'(m_busy));
    check("out_tx", 32'(out_tx), 32'(m_frame));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          cnt;
    logic [10:0] aa_frame;
    logic [10:0] exp_frame;
    aa_frame = make_frame(8'hAA);

    // Reset held two cycles
    reset = 1'b0; baud_sel = 2'b10; data_in = 8'hAA;
    steps(2);
    check("rst_out_tx", 32'(out_tx), 32'h7FF);
    check("rst_tx",     32'(tx),     32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_intx",   32'(intx),   32'd0);
    check("rst_inrx",   32'(inrx),   32'd0);

    // First frame load 217 cycles after release
    reset = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (busy !== 1'b1 && cnt < 400);
    check("first_load_cycles", 32'(cnt), 32'd217);
`ifdef UART_TX_PARITY_EN
    exp_frame = 11'h554;
`else
    exp_frame = 11'h754;
`endif
    check("frame_aa", 32'(out_tx), 32'(exp_frame));
    check("bit0_tx",  32'(tx),     32'd0);

    // Walk the bits; data_in changes during bit 4 must not disturb this frame
    for (int b = 1; b <= 10; b++) begin
      if (b == 5) begin
        steps(100);
        data_in = 8'h0F;
        steps(117);
      end else begin
        steps(217);
      end
      check("bit_tx", 32'(tx), 32'(aa_frame[b]));
      check("frame_hold", 32'(out_tx), 32'(aa_frame));
    end
    steps(217);
`ifdef UART_TX_PARITY_EN
    exp_frame = 11'h41E;
`else
    exp_frame = 11'h61E;
`endif
    check("frame_0f_after_2387", 32'(out_tx), 32'(exp_frame));

    // intx and inrx periods
    cnt = 0;
    do begin step(); cnt++; end while (intx !== 1'b1 && cnt < 400);
    cnt = 0;
    do begin step(); cnt++; end while (intx !== 1'b1 && cnt < 400);
    check("intx_period", 32'(cnt), 32'd217);
    cnt = 0;
    do begin step(); cnt++; end while (inrx !== 1'b1 && cnt < 40);
    cnt = 0;
    do begin step(); cnt++; end while (inrx !== 1'b1 && cnt < 40);
    check("inrx_period", 32'(cnt), 32'd13);

    // Parity of 8'h01
    data_in = 8'h01;
    cnt = 0;
    do begin step(); cnt++; end while (out_tx[8:1] !== 8'h01 && cnt < 3000);
    check("frame_01", 32'(out_tx), 32'h602);

    // Randomized data and baud changes against the model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) baud_sel = 2'($urandom_range(1, 3));
      data_in = 8'($urandom);
      steps(int'($urandom_range(1, 500)));
    end

    // Baud switch 10 -> 00 mid-frame
    baud_sel = 2'b10;
    steps(217 * 5 + 37);
    baud_sel = 2'b00;
    cnt = 0;
    do begin step(); cnt++; end while (intx !== 1'b1 && cnt < 11000);
    check("intx_after_baud_switch", 32'(cnt), 32'd10416);

    // Reset mid-frame aborts immediately, then restarts cleanly
    baud_sel = 2'b10;
    steps(217 * 5 + 60);
    reset = 1'b0;
    step();
    check("abort_tx",     32'(tx),     32'd1);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_out_tx", 32'(out_tx), 32'h7FF);
    reset = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (busy !== 1'b1 && cnt < 400);
    check("restart_load_cycles", 32'(cnt), 32'd217);
    steps(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
